// File: rtl/adder_checker.sv
// Self-checking monitor for an adder: compares adder_out against a wrapped
// in_0 + in_1, counts pass/fail over a run and records the first mismatch.
module adder_checker #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_checks,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] adder_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [DATA_W-1:0] first_fail_got
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          num_q, num_d;
  logic [CNT_W-1:0]          pass_q, pass_d;
  logic [CNT_W-1:0]          fail_q, fail_d;
  logic [CNT_W-1:0]          ffi_q, ffi_d;
  logic signed [DATA_W-1:0]  ffe_q, ffe_d;
  logic signed [DATA_W-1:0]  ffg_q, ffg_d;
  logic                      err_q, err_d;

  logic signed [DATA_W-1:0]  exp_sum;
  logic                      match;
  logic                      xfer;
  logic [CNT_W-1:0]          idx_inc;

  // Two's-complement sum truncated to DATA_W bits: overflow wraps, never saturates.
  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] full;
    full = a + b;
    return full[DATA_W-1:0];
  endfunction

  assign exp_sum  = wrap_add(in_0, in_1);
  assign match    = (adder_out == exp_sum);
  assign in_ready = (state_q == S_RUN) && (idx_q < num_q);
  assign xfer     = in_valid && in_ready;
  assign idx_inc  = idx_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    ffe_d   = ffe_q;
    ffg_d   = ffg_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          num_d   = num_checks;
          idx_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          ffi_d   = '0;
          ffe_d   = '0;
          ffg_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          idx_d = idx_inc;
          if (match) begin
            pass_d = pass_q + CNT_W'(1);
          end else begin
            fail_d = fail_q + CNT_W'(1);
            err_d  = 1'b1;
            // Only the first mismatch of a run is captured.
            if (fail_q == '0) begin
              ffi_d = idx_q;
              ffe_d = exp_sum;
              ffg_d = adder_out;
            end
          end
          if (idx_inc == num_q) state_d = S_DONE;
        end else if (!in_ready) begin
          // Reached only by an empty run (num_checks == 0).
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      ffe_q   <= '0;
      ffg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      ffe_q   <= ffe_d;
      ffg_q   <= ffg_d;
      err_q   <= err_d;
    end
  end

  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign error          = err_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_exp = ffe_q;
  assign first_fail_got = ffg_q;

endmodule
